// File: rtl/multiplicador_kca_pkg.sv
// Shared types and sizing constants for the multiplicador_kca shift-add multiplier.
// Optional signed arithmetic is selected by defining MULT_KCA_SIGNED_EN.
package multiplicador_kca_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

  localparam int KCA_N      = 8;
  localparam int KCA_CNT_W  = cnt_width(KCA_N);
  localparam int KCA_PROD_W = 2 * KCA_N + 1;

endpackage

// File: rtl/multiplicador_kca_if.sv
// Start/Ready handshake bundle between a host controller and the multiplier.
// The host drives the master side; the multiplier is the slave.
interface multiplicador_kca_if
  import multiplicador_kca_pkg::*;
#(
  parameter int N = KCA_N
);

  logic         Start;
  logic [N-1:0] Multiplicando;
  logic [N-1:0] Multiplicador;
  logic [2*N:0] Producto;
  logic         Ready;

  modport master (
    output Start,
    output Multiplicando,
    output Multiplicador,
    input  Producto,
    input  Ready
  );

  modport slave (
    input  Start,
    input  Multiplicando,
    input  Multiplicador,
    output Producto,
    output Ready
  );

endinterface

// File: rtl/multiplicador_kca_ctrl.sv
// Control FSM for multiplicador_kca: IDLE/CALC/DONE sequencing, step counter and Ready.
// Datapath strobes are decoded from the registered state so they align with the step edge.
module multiplicador_kca_ctrl
  import multiplicador_kca_pkg::*;
#(
  parameter int N = KCA_N
) (
  input  logic Clock,
  input  logic Reset,
  input  logic i_start,
  output logic o_load,
  output logic o_step,
  output logic o_last,
  output logic o_ready
);

  localparam int               CNT_W    = cnt_width(N);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

  state_e           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ready;

  // Start is only honoured outside CALC, so an operation in flight is never disturbed.
  assign o_load  = i_start && (r_state != CALC);
  assign o_step  = (r_state == CALC);
  assign o_last  = o_step && (r_cnt == LAST_CNT);
  assign o_ready = r_ready;

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_ready <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_state <= CALC;
            r_cnt   <= '0;
          end
        end
        CALC: begin
          if (r_cnt == LAST_CNT) begin
            r_state <= DONE;
            r_cnt   <= '0;
            r_ready <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DONE: begin
          if (i_start) begin
            r_state <= CALC;
            r_cnt   <= '0;
            r_ready <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/multiplicador_kca.sv
// Sequential shift-add multiplier, one partial product per clock, 2N+1-bit registered result.
// Define MULT_KCA_SIGNED_EN for two's-complement operands (last step subtracts).
module multiplicador_kca
  import multiplicador_kca_pkg::*;
#(
  parameter int N = KCA_N
) (
  input  logic                Clock,
  input  logic                Reset,
  multiplicador_kca_if.slave  bus
);

  logic [N-1:0] r_mcand;
  logic [N-1:0] r_mul;
  logic [N-1:0] r_acc_hi;
  logic [2*N:0] r_producto;

  logic         w_load;
  logic         w_step;
  logic         w_last;
  logic         w_ready;
  logic [N:0]   w_acc_ext;
  logic [N:0]   w_addend;
  logic [N:0]   w_sum;
  logic         w_ext_bit;
  logic [2*N:0] w_product;

  multiplicador_kca_ctrl #(
    .N (N)
  ) u_ctrl (
    .Clock   (Clock),
    .Reset   (Reset),
    .i_start (bus.Start),
    .o_load  (w_load),
    .o_step  (w_step),
    .o_last  (w_last),
    .o_ready (w_ready)
  );

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_acc_ext = '0;
    w_addend  = '0;
    w_sum     = '0;
    w_ext_bit = 1'b0;
`ifdef MULT_KCA_SIGNED_EN
    w_acc_ext = {r_acc_hi[N-1], r_acc_hi};
    if (r_mul[0]) w_addend = {r_mcand[N-1], r_mcand};
    // The multiplier MSB carries negative weight, hence the subtraction on the final step.
    w_sum     = w_last ? (w_acc_ext - w_addend) : (w_acc_ext + w_addend);
    w_ext_bit = w_sum[N];
`else
    w_acc_ext = {1'b0, r_acc_hi};
    if (r_mul[0]) w_addend = {1'b0, r_mcand};
    w_sum     = w_acc_ext + w_addend;
    w_ext_bit = 1'b0;
`endif
  end

  // Result as it will look after the current step's right shift.
  assign w_product = {w_ext_bit, w_sum, r_mul[N-1:1]};

  // NOTE: datapath registers are plain flops, so all of them are cleared by the async reset.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_mcand    <= '0;
      r_mul      <= '0;
      r_acc_hi   <= '0;
      r_producto <= '0;
    end else if (w_load) begin
      r_mcand  <= bus.Multiplicando;
      r_mul    <= bus.Multiplicador;
      r_acc_hi <= '0;
    end else if (w_step) begin
      r_acc_hi <= w_sum[N:1];
      r_mul    <= {w_sum[0], r_mul[N-1:1]};
      if (w_last) r_producto <= w_product;
    end
  end

  assign bus.Producto = r_producto;
  assign bus.Ready    = w_ready;

endmodule

// File: tb/tb_multiplicador_kca.sv
// Directed self-checking bench for multiplicador_kca; expected values are hand-computed.
// Signed expectations are selected when MULT_KCA_SIGNED_EN is defined.
module tb_multiplicador_kca;
  import multiplicador_kca_pkg::*;

  localparam int N = 8;

`ifdef MULT_KCA_SIGNED_EN
  localparam logic [16:0] EXP_DF_D7 = 17'h00549;
  localparam logic [16:0] EXP_FF_FF = 17'h00001;
`else
  localparam logic [16:0] EXP_DF_D7 = 17'h0BB49;
  localparam logic [16:0] EXP_FF_FF = 17'h0FE01;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  multiplicador_kca_if #(.N(N)) bus ();

  multiplicador_kca #(.N(N)) dut (
    .Clock (clk),
    .Reset (rst_n),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One-cycle Start pulse; operands are scrambled afterwards to prove they were latched.
  task automatic start_pulse(input logic [N-1:0] a, input logic [N-1:0] b);
    @(negedge clk);
    bus.Start         = 1'b1;
    bus.Multiplicando = a;
    bus.Multiplicador = b;
    @(negedge clk);
    bus.Start         = 1'b0;
    bus.Multiplicando = ~a;
    bus.Multiplicador = b ^ 8'h5A;
  endtask

  // Counts edges until Ready; a budget of 20 edges bounds the wait.
  task automatic wait_ready(output int edges);
    edges = 0;
    while (edges < 20 && !bus.Ready) begin
      @(negedge clk);
      edges++;
    end
  endtask

  initial begin
    int edges;
    int last_idx;
    int pulses;

    bus.Start         = 1'b0;
    bus.Multiplicando = '0;
    bus.Multiplicador = '0;

    // Reset state
    #1;
    check("reset_ready", 32'(bus.Ready), 32'd0);
    check("reset_prod", 32'(bus.Producto), 32'd0);
    @(negedge clk);
    @(negedge clk);
    check("reset_held_ready", 32'(bus.Ready), 32'd0);
    rst_n = 1'b1;

    // 1: 0xDF * 0xD7
    start_pulse(8'hDF, 8'hD7);
    check("t1_calc_ready", 32'(bus.Ready), 32'd0);
    check("t1_calc_prod_held", 32'(bus.Producto), 32'd0);
    wait_ready(edges);
    check("t1_latency", 32'(edges), 32'd8);
    check("t1_prod", 32'(bus.Producto), 32'(EXP_DF_D7));
    @(negedge clk);
    check("t1_done_ready_held", 32'(bus.Ready), 32'd1);
    check("t1_done_prod_held", 32'(bus.Producto), 32'(EXP_DF_D7));

    // 2: 0xFF * 0xFF from DONE
    start_pulse(8'hFF, 8'hFF);
    check("t2_ready_drop", 32'(bus.Ready), 32'd0);
    check("t2_calc_prod_held", 32'(bus.Producto), 32'(EXP_DF_D7));
    wait_ready(edges);
    check("t2_latency", 32'(edges), 32'd8);
    check("t2_prod", 32'(bus.Producto), 32'(EXP_FF_FF));

    // 3: zero operands
    start_pulse(8'h00, 8'hA5);
    wait_ready(edges);
    check("t3a_latency", 32'(edges), 32'd8);
    check("t3a_prod", 32'(bus.Producto), 32'd0);
    start_pulse(8'h37, 8'h00);
    wait_ready(edges);
    check("t3b_latency", 32'(edges), 32'd8);
    check("t3b_prod", 32'(bus.Producto), 32'd0);

    // 4: Start mid-CALC is ignored
    start_pulse(8'hDF, 8'hD7);
    repeat (3) @(negedge clk);
    start_pulse(8'h03, 8'h05);
    wait_ready(edges);
    check("t4_latency_rest", 32'(edges), 32'd3);
    check("t4_prod", 32'(bus.Producto), 32'(EXP_DF_D7));
    @(negedge clk);
    check("t4_no_relaunch", 32'(bus.Ready), 32'd1);

    // 5: reset during CALC step 4
    start_pulse(8'hFF, 8'hFF);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t5_reset_ready", 32'(bus.Ready), 32'd0);
    check("t5_reset_prod", 32'(bus.Producto), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    start_pulse(8'h03, 8'h05);
    wait_ready(edges);
    check("t5_latency", 32'(edges), 32'd8);
    check("t5_prod", 32'(bus.Producto), 32'h0000F);

    // 6: Start held high -> back-to-back operations
    @(negedge clk);
    bus.Start         = 1'b1;
    bus.Multiplicando = 8'h10;
    bus.Multiplicador = 8'h10;
    last_idx = -1;
    pulses   = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (bus.Ready) begin
        check("t6_prod", 32'(bus.Producto), 32'h00100);
        if (last_idx >= 0) check("t6_period", 32'(i - last_idx), 32'd9);
        else check("t6_first", 32'(i), 32'd9);
        last_idx = i;
        pulses++;
      end
    end
    bus.Start = 1'b0;
    check("t6_pulses", 32'(pulses), 32'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
